// File: rtl/pc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_pkg : shared types and constants for the fetch PC generator
// Revision: 1.0
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    SRC_RESET   = 3'd0,
    SRC_TRAP    = 3'd1,
    SRC_EXREDIR = 3'd2,
    SRC_MISPRED = 3'd3,
    SRC_HOLD    = 3'd4,
    SRC_RAS     = 3'd5,
    SRC_JUMP    = 3'd6,
    SRC_SEQ     = 3'd7
  } pc_src_t;

endpackage
`default_nettype wire

// File: rtl/pc_gen_return_addr_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// return_addr_stack : circular return-address stack, overwrites oldest on overflow
// Revision: 1.0
// ---------------------------------------------------------------------------
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;

  assign top_ptr = wptr - PTR_W'(1);
  assign rdata   = mem[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);

  // Clear dominates; a pop is only honoured when there is something to pop.
  assign do_push    = push & ~clear;
  assign do_pop     = pop & ~clear & ~empty;
  assign do_replace = do_push & do_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (do_replace) begin
      wptr  <= wptr;
      count <= count;
    end else if (do_push) begin
      wptr <= wptr + PTR_W'(1);
      if (!full) begin
        count <= count + CNT_W'(1);
      end
    end else if (do_pop) begin
      wptr  <= top_ptr;
      count <= count - CNT_W'(1);
    end
  end

  // Storage is intentionally not reset; entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_replace) begin
        mem[top_ptr] <= wdata;
      end else if (do_push) begin
        mem[wptr] <= wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_gen : fetch PC generator with priority next-PC mux and return prediction
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  input  logic            mispredict,
  input  logic [XLEN-1:0] mispredict_pc,
  input  logic            id_jump,
  input  logic [XLEN-1:0] id_jump_offset,
  input  logic            id_call,
  input  logic            id_ret,
  input  logic            ras_clear,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      pc_src,
  output logic            ras_hit,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] INC = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] pc_next;
  pc_src_t         src_next;
  logic            hit_next;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_rdata;

  always_comb begin
    pc_next  = pc + INC;
    src_next = SRC_SEQ;
    hit_next = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (trap_valid) begin
      pc_next  = trap_target;
      src_next = SRC_TRAP;
    end else if (ex_redirect) begin
      if (mispredict) begin
        pc_next  = mispredict_pc + INC;
        src_next = SRC_MISPRED;
      end else begin
        pc_next  = ex_target;
        src_next = SRC_EXREDIR;
      end
    end else if (stall) begin
      pc_next  = pc;
      src_next = SRC_HOLD;
    end else begin
      // The ID instruction sits at pc-4, so its return address is pc itself.
      ras_push = id_call & ~ras_clear;
      if (id_ret && !ras_empty && !ras_clear) begin
        pc_next  = ras_rdata;
        src_next = SRC_RAS;
        hit_next = 1'b1;
        ras_pop  = 1'b1;
      end else if (id_jump) begin
        pc_next  = pc + id_jump_offset - INC;
        src_next = SRC_JUMP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_VECTOR;
      pc_src  <= SRC_RESET;
      ras_hit <= 1'b0;
    end else begin
      pc      <= pc_next;
      pc_src  <= src_next;
      ras_hit <= hit_next;
    end
  end

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .clear (ras_clear),
    .wdata (pc),
    .rdata (ras_rdata),
    .empty (ras_empty),
    .full  (ras_full)
  );

endmodule
`default_nettype wire
